lsu_mem_controller: RTL

- Sequences the load/store unit's single L1 data-cache port.
- Each transaction picks either the committed store at the STQ head or the oldest issuable load.
- Drives the LDQ memory-stage index consumed by the dependency checker, honours its kill, and runs a valid/ready request plus response handshake with L1.
- Returns executed/succeeded pulses to the LDQ and STQ, and drains in-flight loads on a pipeline flush.

---
 rtl/lsu_mem_controller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_controller.sv
// Single-port L1 data-cache sequencer for the load/store unit: arbitrates the committed STQ head
// against the oldest issuable load and runs one request/response transaction at a time.
module lsu_mem_controller #(
    parameter  int XLEN          = 32,
    parameter  int LDQ_SIZE      = 8,
    parameter  int ROB_TAG_WIDTH = 5,
    localparam int IDX_W         = $clog2(LDQ_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LDQ_SIZE-1:0]      ldq_issuable,
    input  logic [IDX_W-1:0]         ldq_head,
    input  logic [XLEN-1:0]          ldq_sel_addr,
    input  logic                     stq_commit_pending,
    input  logic [XLEN-1:0]          stq_head_addr,
    input  logic [XLEN-1:0]          stq_head_data,
    input  logic [ROB_TAG_WIDTH-1:0] stq_head_rob_tag,
    input  logic                     kill_mem_req,
    input  logic                     flush,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_write,
    output logic [XLEN-1:0]          mem_req_addr,
    output logic [XLEN-1:0]          mem_req_wdata,
    input  logic                     mem_resp_valid,
    input  logic [XLEN-1:0]          mem_resp_data,
    output logic [IDX_W-1:0]         ldq_mem_stage_index,
    output logic                     load_executed,
    output logic                     load_killed,
    output logic                     load_succeeded,
    output logic [IDX_W-1:0]         load_succeeded_index,
    output logic [XLEN-1:0]          load_result,
    output logic                     store_succeeded,
    output logic [ROB_TAG_WIDTH-1:0] store_succeeded_rob_tag,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

    state_e                   state_q;
    logic                     is_store_q;
    logic [XLEN-1:0]          st_addr_q;
    logic [XLEN-1:0]          st_data_q;
    logic [ROB_TAG_WIDTH-1:0] st_tag_q;
    logic [IDX_W-1:0]         ldq_idx_q;
    logic                     load_executed_q;
    logic                     load_killed_q;
    logic                     load_succeeded_q;
    logic [IDX_W-1:0]         load_succ_idx_q;
    logic [XLEN-1:0]          load_result_q;
    logic                     store_succeeded_q;
    logic [ROB_TAG_WIDTH-1:0] store_tag_q;

    logic                     sel_found_d;
    logic [IDX_W-1:0]         sel_idx_d;
    logic [IDX_W-1:0]         cand;

    // Oldest-first scan from ldq_head; walking offsets downward lets the smallest offset win.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        sel_found_d = 1'b0;
        sel_idx_d   = '0;
        cand        = '0;
        for (int i = LDQ_SIZE - 1; i >= 0; i--) begin
            cand = ldq_head + IDX_W'(i);
            if (ldq_issuable[cand]) begin
                sel_found_d = 1'b1;
                sel_idx_d   = cand;
            end
        end
    end

    logic in_req;
    assign in_req = (state_q == REQ);

    // A load request is withdrawn the instant it is killed or flushed, so the L1 never sees it.
    assign mem_req_valid = in_req && (is_store_q || !(kill_mem_req || flush));
    assign mem_req_write = in_req && is_store_q;
    assign mem_req_addr  = !in_req ? '0 : (is_store_q ? st_addr_q : ldq_sel_addr);
    assign mem_req_wdata = (in_req && is_store_q) ? st_data_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            is_store_q        <= 1'b0;
            st_addr_q         <= '0;
            st_data_q         <= '0;
            st_tag_q          <= '0;
            ldq_idx_q         <= '0;
            load_executed_q   <= 1'b0;
            load_killed_q     <= 1'b0;
            load_succeeded_q  <= 1'b0;
            load_succ_idx_q   <= '0;
            load_result_q     <= '0;
            store_succeeded_q <= 1'b0;
            store_tag_q       <= '0;
        end else begin
            // NOTE: pulses default low with non-blocking assignments; a later branch overrides.
            load_executed_q   <= 1'b0;
            load_killed_q     <= 1'b0;
            load_succeeded_q  <= 1'b0;
            store_succeeded_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (stq_commit_pending) begin
                        is_store_q <= 1'b1;
                        st_addr_q  <= stq_head_addr;
                        st_data_q  <= stq_head_data;
                        st_tag_q   <= stq_head_rob_tag;
                        state_q    <= REQ;
                    end else if (sel_found_d) begin
                        is_store_q <= 1'b0;
                        ldq_idx_q  <= sel_idx_d;
                        state_q    <= REQ;
                    end
                end

                REQ: begin
                    if (is_store_q) begin
                        if (mem_req_ready) state_q <= WAIT;
                    end else if (flush) begin
                        state_q <= IDLE;
                    end else if (kill_mem_req) begin
                        load_killed_q <= 1'b1;
                        state_q       <= IDLE;
                    end else if (mem_req_ready) begin
                        load_executed_q <= 1'b1;
                        state_q         <= WAIT;
                    end
                end

                WAIT: begin
                    if (mem_resp_valid) begin
                        if (is_store_q) begin
                            store_succeeded_q <= 1'b1;
                            store_tag_q       <= st_tag_q;
                        end else if (!flush) begin
                            load_succeeded_q <= 1'b1;
                            load_succ_idx_q  <= ldq_idx_q;
                            load_result_q    <= mem_resp_data;
                        end
                        state_q <= IDLE;
                    end else if (!is_store_q && flush) begin
                        state_q <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (mem_resp_valid) state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign ldq_mem_stage_index     = ldq_idx_q;
    assign load_executed           = load_executed_q;
    assign load_killed             = load_killed_q;
    assign load_succeeded          = load_succeeded_q;
    assign load_succeeded_index    = load_succ_idx_q;
    assign load_result             = load_result_q;
    assign store_succeeded         = store_succeeded_q;
    assign store_succeeded_rob_tag = store_tag_q;
    assign busy                    = (state_q != IDLE);

endmodule
